// File: rtl/vid_bank_writer.sv
// Vertex-id bank writer: commits accepted per-epoch bank rows to K SRAM banks
// at per-bank auto-incrementing row addresses, with overflow and row tracking.
// Bank 0 sits in the most significant slice of every per-bank vector, so packed
// array position p corresponds to bank K-1-p.
module vid_bank_writer #(
  parameter int unsigned K         = 16,
  parameter int unsigned Q         = 16,
  parameter int unsigned VID_BW    = 12,
  parameter int unsigned ADDR_BW   = 4,
  parameter int unsigned NUM_EPOCH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [K-1:0]               in_wen,
  input  logic [K*Q*VID_BW-1:0]      in_wdata,
  output logic [K-1:0]               sram_wsb,
  output logic [K*ADDR_BW-1:0]       sram_waddr,
  output logic [K*Q*VID_BW-1:0]      sram_wdata,
  output logic [7:0]                 epoch,
  output logic [K*(ADDR_BW+1)-1:0]   row_cnt,
  output logic [K-1:0]               overflow,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned RW    = Q * VID_BW;
  localparam int unsigned CW    = ADDR_BW + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_BW;
  localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
  localparam logic [8:0]    LastEpoch = 9'(NUM_EPOCH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                     state_q, state_d;
  logic [K-1:0]               wsb_q, wsb_d;
  logic [K-1:0][ADDR_BW-1:0]  waddr_q, waddr_d;
  logic [K-1:0][RW-1:0]       wdata_q, wdata_d;
  // Write pointer doubles as the row count: both advance together and stop at DEPTH.
  logic [K-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [K-1:0]               ovf_q, ovf_d;
  logic [7:0]                 epoch_q, epoch_d;
  // 9-bit epoch tracker so the 8-bit wrap at 256 still signals completion.
  logic [8:0]                 ecnt_q, ecnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic accept;
  logic clear;

  assign accept = (state_q == StRun) && in_valid;
  assign clear  = start && (state_q != StRun);

  // Next-state: pass control, epoch counting and per-bank write issue.
  always_comb begin
    state_d = state_q;
    wsb_d   = '1;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    epoch_d = epoch_q;
    ecnt_d  = ecnt_q;

    if (clear) begin
      state_d = StRun;
      cnt_d   = '0;
      ovf_d   = '0;
      epoch_d = '0;
      ecnt_d  = '0;
    end

    if (accept) begin
      epoch_d = epoch_q + 8'd1;
      ecnt_d  = ecnt_q + 9'd1;
      if (ecnt_q == LastEpoch) begin
        state_d = StDone;
      end
      for (int p = 0; p < K; p++) begin
        if (in_wen[p]) begin
          if (cnt_q[p] < DepthC) begin
            wsb_d[p]   = 1'b0;
            waddr_d[p] = cnt_q[p][ADDR_BW-1:0];
            wdata_d[p] = in_wdata[p*RW +: RW];
            cnt_d[p]   = cnt_q[p] + CW'(1);
          end else begin
            ovf_d[p] = 1'b1;
          end
        end
      end
    end

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wsb_q   <= '1;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      epoch_q <= '0;
      ecnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wsb_q   <= wsb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      epoch_q <= epoch_d;
      ecnt_q  <= ecnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sram_wsb   = wsb_q;
  assign sram_waddr = waddr_q;
  assign sram_wdata = wdata_q;
  assign epoch      = epoch_q;
  assign row_cnt    = cnt_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vid_bank_writer.sv
// Directed self-checking bench for vid_bank_writer.
module tb_vid_bank_writer;

  localparam int unsigned K       = 16;
  localparam int unsigned Q       = 16;
  localparam int unsigned VID_BW  = 12;
  localparam int unsigned ADDR_BW = 4;
  localparam int unsigned RW      = Q * VID_BW;
  localparam int unsigned CW      = ADDR_BW + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     in_valid = 1'b0;
  logic [K-1:0]             in_wen = '0;
  logic [K*RW-1:0]          in_wdata = '0;
  logic [K-1:0]             sram_wsb;
  logic [K*ADDR_BW-1:0]     sram_waddr;
  logic [K*RW-1:0]          sram_wdata;
  logic [7:0]               epoch;
  logic [K*CW-1:0]          row_cnt;
  logic [K-1:0]             overflow;
  logic                     busy;
  logic                     done;

  int n_chk = 0;
  int n_bad = 0;

  vid_bank_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_wen     (in_wen),
    .in_wdata   (in_wdata),
    .sram_wsb   (sram_wsb),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .epoch      (epoch),
    .row_cnt    (row_cnt),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [RW-1:0] row_of(input int seed, input int b);
    logic [VID_BW-1:0] tag;
    tag = VID_BW'(seed * 16 + b + 1);
    return {Q{tag}};
  endfunction

  function automatic logic [ADDR_BW-1:0] addr_of(input int b);
    return sram_waddr[(K-1-b)*ADDR_BW +: ADDR_BW];
  endfunction

  function automatic logic [RW-1:0] data_of(input int b);
    return sram_wdata[(K-1-b)*RW +: RW];
  endfunction

  function automatic logic [CW-1:0] cnt_of(input int b);
    return row_cnt[(K-1-b)*CW +: CW];
  endfunction

  task automatic cyc(input logic v, input logic [K-1:0] w, input int seed);
    in_valid = v;
    in_wen   = w;
    for (int b = 0; b < K; b++) in_wdata[(K-1-b)*RW +: RW] = row_of(seed, b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_rst();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    do_rst();
    chk("rst_wsb", RW'(sram_wsb), RW'(16'hFFFF));
    chk("rst_epoch", RW'(epoch), 0);
    chk("rst_rowcnt", RW'(row_cnt), 0);
    chk("rst_ovf", RW'(overflow), 0);
    chk("rst_busy_done", RW'({busy, done}), 0);

    // Single bank, sequential addresses
    pulse_start();
    chk("start_busy", RW'(busy), 1);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 16'h8000, n);
      chk($sformatf("b0_wsb%0d", n), RW'(sram_wsb), RW'(16'h7FFF));
      chk($sformatf("b0_addr%0d", n), RW'(addr_of(0)), RW'(n));
      chk($sformatf("b0_data%0d", n), data_of(0), row_of(n, 0));
    end
    cyc(1'b0, 16'h0000, 0);
    chk("b0_idle_wsb", RW'(sram_wsb), RW'(16'hFFFF));
    chk("b0_rowcnt", RW'(row_cnt), RW'({5'd3, 75'd0}));
    chk("b0_epoch", RW'(epoch), 3);

    // Simultaneous banks 0 and 15 in a fresh pass
    do_rst();
    pulse_start();
    cyc(1'b1, 16'h8001, 5);
    chk("sim_wsb", RW'(sram_wsb), RW'(16'h7FFE));
    chk("sim_addr0", RW'(addr_of(0)), 0);
    chk("sim_addr15", RW'(addr_of(15)), 0);
    chk("sim_data0", data_of(0), row_of(5, 0));
    chk("sim_data15", data_of(15), row_of(5, 15));

    // Overflow on bank 7
    for (int n = 0; n < 16; n++) begin
      cyc(1'b1, 16'h0100, 20 + n);
      chk($sformatf("ov_wsb%0d", n), RW'(sram_wsb), RW'(16'hFEFF));
      chk($sformatf("ov_addr%0d", n), RW'(addr_of(7)), RW'(n));
    end
    chk("ov_last_data", data_of(7), row_of(35, 7));
    chk("ov_none_yet", RW'(overflow), 0);
    cyc(1'b1, 16'h0100, 40);
    chk("ov17_wsb", RW'(sram_wsb), RW'(16'hFFFF));
    chk("ov17_flag", RW'(overflow), RW'(16'h0100));
    chk("ov17_cnt7", RW'(cnt_of(7)), 16);
    chk("ov17_addr7_hold", RW'(addr_of(7)), 15);
    chk("hold_data0", data_of(0), row_of(5, 0));
    chk("ov_epoch", RW'(epoch), 18);

    // Valid gating in RUN, then in IDLE
    for (int n = 0; n < 5; n++) begin
      cyc(1'b0, 16'hFFFF, 50);
      chk($sformatf("gate_run_wsb%0d", n), RW'(sram_wsb), RW'(16'hFFFF));
    end
    chk("gate_run_epoch", RW'(epoch), 18);
    chk("ov_sticky", RW'(overflow), RW'(16'h0100));
    do_rst();
    for (int n = 0; n < 5; n++) begin
      cyc(1'b1, 16'hFFFF, 51);
      chk($sformatf("gate_idle_wsb%0d", n), RW'(sram_wsb), RW'(16'hFFFF));
    end
    chk("gate_idle_epoch", RW'(epoch), 0);

    // Reset mid-pass
    pulse_start();
    for (int n = 0; n < 10; n++) cyc(1'b1, 16'hFFFF, 60 + n);
    chk("mid_wsb", RW'(sram_wsb), 0);
    chk("mid_addr3", RW'(addr_of(3)), 9);
    do_rst();
    chk("mid_rst_wsb", RW'(sram_wsb), RW'(16'hFFFF));
    chk("mid_rst_epoch", RW'(epoch), 0);
    chk("mid_rst_rowcnt", RW'(row_cnt), 0);
    chk("mid_rst_busy", RW'(busy), 0);
    pulse_start();
    cyc(1'b1, 16'hFFFF, 7);
    chk("restart_wsb", RW'(sram_wsb), 0);
    chk("restart_addr0", RW'(addr_of(0)), 0);
    chk("restart_addr15", RW'(addr_of(15)), 0);
    chk("restart_data9", data_of(9), row_of(7, 9));

    // Full pass; last epoch writes bank 15 to show the strobe lands in DONE
    do_rst();
    pulse_start();
    for (int n = 0; n < 255; n++) cyc(1'b1, 16'h0000, 0);
    chk("fp_epoch255", RW'(epoch), 255);
    chk("fp_busy255", RW'({busy, done}), RW'(2'b10));
    cyc(1'b1, 16'h0001, 9);
    chk("fp_done", RW'({busy, done}), RW'(2'b01));
    chk("fp_epoch_wrap", RW'(epoch), 0);
    chk("fp_last_wsb", RW'(sram_wsb), RW'(16'hFFFE));
    chk("fp_last_data15", data_of(15), row_of(9, 15));
    chk("fp_cnt15", RW'(cnt_of(15)), 1);
    cyc(1'b1, 16'hFFFF, 10);
    chk("fp_hold_wsb", RW'(sram_wsb), RW'(16'hFFFF));
    chk("fp_hold_epoch", RW'(epoch), 0);
    chk("fp_hold_done", RW'(done), 1);
    chk("fp_hold_cnt15", RW'(cnt_of(15)), 1);
    pulse_start();
    chk("fp_restart", RW'({busy, done}), RW'(2'b10));
    chk("fp_restart_cnt", RW'(row_cnt), 0);
    // start during RUN is ignored: counts keep advancing
    cyc(1'b1, 16'h8000, 11);
    start = 1'b1;
    cyc(1'b1, 16'h8000, 12);
    start = 1'b0;
    chk("run_start_ign_addr", RW'(addr_of(0)), 1);
    chk("run_start_ign_epoch", RW'(epoch), 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
